hier_trace_capture: RTL

//  Trace-capture stage directly downstream of the bench's hierarchical probe logic.

---
 rtl/hier_trace_pkg.sv | 17 +
 rtl/hier_trace_fifo.sv | 57 +++++
 rtl/hier_trace_capture.sv | 132 +++++++++++++
 3 files changed

// File: rtl/hier_trace_pkg.sv
// Shared types and helpers for the hierarchical trace-capture stage.
// Used by hier_trace_capture and hier_trace_fifo.
package hier_trace_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } trace_state_t;

    // One extra pointer bit distinguishes full from empty when the indices match.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/hier_trace_fifo.sv
// Power-of-two FIFO with wrap-bit pointers, synchronous flush and a gated head output.
// The head reads as zero whenever the FIFO is empty.
module hier_trace_fifo
    import hier_trace_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic               full,
    output logic               empty,
    output logic [ENTRY_W-1:0] head
);

    localparam int PTR_W  = ptr_w(DEPTH);
    localparam int ADDR_W = PTR_W - 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic               do_push;
    logic               do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

    // A push into a full FIFO is accepted only when a pop frees the slot this cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    assign head = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[ADDR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/hier_trace_capture.sv
// Trigger-started trace capture of probe samples into a FIFO drained over valid/ready.
// Define HIER_TRACE_TIMESTAMP_EN to prefix each entry with a free-running TS_W-bit cycle stamp.
module hier_trace_capture
    import hier_trace_pkg::*;
#(
    parameter int WIDTH   = 2,
    parameter int DEPTH   = 8,
    parameter int CAP_LEN = 16,
    parameter int TS_W    = 16,
`ifdef HIER_TRACE_TIMESTAMP_EN
    localparam int ENTRY_W = TS_W + WIDTH
`else
    localparam int ENTRY_W = WIDTH
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               arm_i,
    input  logic               abort_i,
    input  logic               trig_i,
    input  logic [WIDTH-1:0]   probe_i,
    input  logic               rd_ready_i,
    output logic               rd_valid_o,
    output logic [ENTRY_W-1:0] rd_data_o,
    output trace_state_t       state_o,
    output logic               overflow_o,
    output logic               done_o
);

    localparam logic [15:0] CAP_LAST = 16'(CAP_LEN - 1);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CAP_LEN < 1 || CAP_LEN > 65535 || TS_W < 1) begin : g_bad_params
            $error("hier_trace_capture: illegal parameter set");
        end
    endgenerate

    trace_state_t       state;
    trace_state_t       next_state;
    logic [15:0]        sample_cnt;
    logic               last_sample;
    logic               push;
    logic               enter_armed;
    logic               clear_ovf;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] push_data;

    assign last_sample = (sample_cnt == CAP_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (abort_i) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (arm_i)  next_state = ARMED;
                ARMED:   if (trig_i) next_state = last_sample ? DONE : CAPTURE;
                CAPTURE: if (last_sample) next_state = DONE;
                DONE:    if (arm_i)  next_state = ARMED;
                default: next_state = IDLE;
            endcase
        end
    end

    // Abort masks every other action so nothing is written in the flush cycle.
    always_comb begin
        push        = 1'b0;
        enter_armed = 1'b0;
        clear_ovf   = 1'b0;
        if (!abort_i) begin
            push        = (state == ARMED && trig_i) || (state == CAPTURE);
            enter_armed = arm_i && (state == IDLE || state == DONE);
            clear_ovf   = arm_i && (state == DONE);
        end
    end

    // Counts attempted samples, so dropped writes still advance toward CAP_LEN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)            sample_cnt <= '0;
        else if (enter_armed) sample_cnt <= '0;
        else if (push)        sample_cnt <= sample_cnt + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                           overflow_o <= 1'b0;
        else if (push && fifo_full && !pop)  overflow_o <= 1'b1;
        else if (clear_ovf)                  overflow_o <= 1'b0;
    end

`ifdef HIER_TRACE_TIMESTAMP_EN
    localparam logic [TS_W-1:0] TS_ONE = TS_W'(1);
    logic [TS_W-1:0] ts_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ts_cnt <= '0;
        else       ts_cnt <= ts_cnt + TS_ONE;
    end

    assign push_data = {ts_cnt, probe_i};
`else
    assign push_data = probe_i;
`endif

    assign pop = rd_valid_o && rd_ready_i;

    hier_trace_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (abort_i),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (rd_data_o)
    );

    assign rd_valid_o = !fifo_empty;
    assign state_o    = state;
    assign done_o     = (state == DONE);

endmodule
